// File: rtl/axi_icn_pkg.sv
// Shared definitions for the AXI4 interconnect slave-side blocks.
package axi_icn_pkg;

   localparam int TRANS_MST_ID_W    = 5;
   localparam int TRANS_BURST_W     = 2;
   localparam int TRANS_DATA_LEN_W  = 3;
   localparam int TRANS_DATA_SIZE_W = 3;
   localparam int TRANS_WR_RESP_W   = 2;

   // Slave AR channel state: IDLE has nothing presented, PEND holds s_ARVALID high.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } ar_state_t;

   // Width of a master index; a single master still needs one bit.
   function automatic int mst_id_w(input int mst_amt);
      return (mst_amt > 1) ? $clog2(mst_amt) : 1;
   endfunction

endpackage

// File: rtl/sa_order_fifo.sv
// Synchronous ordering FIFO: remembers which master owns each accepted read burst.
module sa_order_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Storage write; contents need no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop keep count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sa_read_arbiter.sv
// Slave-side read arbiter: round-robin shares one slave AR channel between the
// per-master dispatchers and steers R bursts back in AR acceptance order.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no AR presented to the slave (s_ARVALID_o = 0)
//   ST_PEND | AR payload registered and presented (s_ARVALID_o = 1)
module sa_read_arbiter
   import axi_icn_pkg::*;
#(
   parameter int MST_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int DATA_WIDTH        = 32,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = axi_icn_pkg::TRANS_MST_ID_W,
   parameter int TRANS_BURST_W     = axi_icn_pkg::TRANS_BURST_W,
   parameter int TRANS_DATA_LEN_W  = axi_icn_pkg::TRANS_DATA_LEN_W,
   parameter int TRANS_DATA_SIZE_W = axi_icn_pkg::TRANS_DATA_SIZE_W,
   parameter int TRANS_WR_RESP_W   = axi_icn_pkg::TRANS_WR_RESP_W
) (
   input  logic                                  ACLK_i,
   input  logic                                  ARESET_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
   input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
   input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
   input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
   input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
   input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
   output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
   output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
   output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
   output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
   output logic                                  s_ARVALID_o,
   input  logic                                  s_ARREADY_i,
   input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
   input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
   input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
   input  logic                                  s_RLAST_i,
   input  logic                                  s_RVALID_i,
   output logic                                  s_RREADY_o,
   output logic [TRANS_MST_ID_W-1:0]             dsp_RID_o,
   output logic [DATA_WIDTH-1:0]                 dsp_RDATA_o,
   output logic [TRANS_WR_RESP_W-1:0]            dsp_RRESP_o,
   output logic                                  dsp_RLAST_o,
   output logic [MST_AMT-1:0]                    dsp_RVALID_o,
   input  logic [MST_AMT-1:0]                    dsp_RREADY_i
);

   localparam int MST_ID_W = mst_id_w(MST_AMT);
   localparam int CNT_W    = $clog2(OUTSTANDING_AMT) + 1;

   ar_state_t                    ar_state;
   logic [MST_ID_W-1:0]          rr_ptr;
   logic [MST_AMT-1:0]           req;
   logic                         gnt_en;
   logic                         gnt_vld;
   logic [MST_ID_W-1:0]          gnt_idx;
   logic [MST_ID_W:0]            cand_sum;
   logic [MST_ID_W-1:0]          cand;

   logic [TRANS_MST_ID_W-1:0]    gnt_id;
   logic [ADDR_WIDTH-1:0]        gnt_addr;
   logic [TRANS_BURST_W-1:0]     gnt_burst;
   logic [TRANS_DATA_LEN_W-1:0]  gnt_len;
   logic [TRANS_DATA_SIZE_W-1:0] gnt_size;

   logic                         fifo_full;
   logic                         fifo_empty;
   logic [CNT_W-1:0]             fifo_count_unused;
   logic [MST_ID_W-1:0]          fifo_head;
   logic                         head_vld;
   logic                         r_pop;

   // A full dispatcher is masked out so it never wins a slot it cannot track.
   assign req = dsp_ARVALID_i & ~dsp_AR_outst_full_i;

   // The output register can take a new AR only when empty or draining this
   // cycle, and only while the ordering FIFO has room; a same-cycle pop does
   // not count as room.
   assign gnt_en = ~ARESET_i & (~s_ARVALID_o | s_ARREADY_i) & ~fifo_full;

   // Round-robin pick: scan offsets high to low so the nearest requester at or
   // after the pointer is the last assignment and wins.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      cand_sum = '0;
      cand     = '0;
      for (int i = MST_AMT - 1; i >= 0; i--) begin
         cand_sum = {1'b0, rr_ptr} + (MST_ID_W + 1)'(i);
         if (cand_sum >= (MST_ID_W + 1)'(MST_AMT)) begin
            cand_sum = cand_sum - (MST_ID_W + 1)'(MST_AMT);
         end
         cand = cand_sum[MST_ID_W-1:0];
         if (gnt_en && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // One-hot accept back to the winning dispatcher, valid for the grant cycle only.
   always_comb begin
      dsp_ARREADY_o = '0;
      for (int m = 0; m < MST_AMT; m++) begin
         dsp_ARREADY_o[m] = gnt_vld && (gnt_idx == MST_ID_W'(m));
      end
   end

   // Select the winner's AR payload slice.
   always_comb begin
      gnt_id    = '0;
      gnt_addr  = '0;
      gnt_burst = '0;
      gnt_len   = '0;
      gnt_size  = '0;
      for (int m = 0; m < MST_AMT; m++) begin
         if (gnt_idx == MST_ID_W'(m)) begin
            gnt_id    = dsp_ARID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
            gnt_addr  = dsp_ARADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_burst = dsp_ARBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
            gnt_len   = dsp_ARLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            gnt_size  = dsp_ARSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
         end
      end
   end

   // AR channel FSM with registered payload, valid and round-robin pointer.
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         ar_state    <= ST_IDLE;
         s_ARVALID_o <= 1'b0;
         s_ARID_o    <= '0;
         s_ARADDR_o  <= '0;
         s_ARBURST_o <= '0;
         s_ARLEN_o   <= '0;
         s_ARSIZE_o  <= '0;
         rr_ptr      <= '0;
      end else begin
         if (gnt_vld) begin
            s_ARID_o    <= gnt_id;
            s_ARADDR_o  <= gnt_addr;
            s_ARBURST_o <= gnt_burst;
            s_ARLEN_o   <= gnt_len;
            s_ARSIZE_o  <= gnt_size;
            rr_ptr      <= (gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : gnt_idx + 1'b1;
         end
         case (ar_state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  ar_state    <= ST_PEND;
                  s_ARVALID_o <= 1'b1;
               end
            end
            ST_PEND: begin
               if (gnt_vld) begin
                  ar_state    <= ST_PEND;
                  s_ARVALID_o <= 1'b1;
               end else if (s_ARREADY_i) begin
                  ar_state    <= ST_IDLE;
                  s_ARVALID_o <= 1'b0;
               end
            end
            default: begin
               ar_state    <= ST_IDLE;
               s_ARVALID_o <= 1'b0;
            end
         endcase
      end
   end

   sa_order_fifo #(
      .WIDTH (MST_ID_W),
      .DEPTH (OUTSTANDING_AMT)
   ) u_order_fifo (
      .clk       (ACLK_i),
      .rst       (ARESET_i),
      .push      (gnt_vld),
      .push_data (gnt_idx),
      .pop       (r_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

   // The slave answers in AR order, so the FIFO head always owns the current R burst.
   assign head_vld = ~fifo_empty;

   // R steering: beats with no owner stall at the slave instead of being dropped.
   always_comb begin
      dsp_RVALID_o = '0;
      for (int m = 0; m < MST_AMT; m++) begin
         dsp_RVALID_o[m] = s_RVALID_i && head_vld && (fifo_head == MST_ID_W'(m));
      end
   end

   assign s_RREADY_o  = ~ARESET_i & head_vld & dsp_RREADY_i[fifo_head];
   assign r_pop       = s_RVALID_i & s_RREADY_o & s_RLAST_i;

   assign dsp_RID_o   = s_RID_i;
   assign dsp_RDATA_o = s_RDATA_i;
   assign dsp_RRESP_o = s_RRESP_i;
   assign dsp_RLAST_o = s_RLAST_i;

endmodule

// File: tb/tb_sa_read_arbiter.sv
// Bench for sa_read_arbiter: directed stimulus, expected AR and R traffic
// queued at issue time and checked by independent monitors.
module tb_sa_read_arbiter;

   localparam int MA = 2;

   typedef struct packed {
      logic [4:0]  id;
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [2:0]  len;
      logic [2:0]  size;
   } ar_t;

   typedef struct packed {
      logic [1:0]  oh;
      logic [31:0] data;
      logic        last;
      logic [4:0]  id;
      logic [1:0]  resp;
   } r_t;

   logic              ACLK_i = 1'b0;
   logic              ARESET_i;
   logic [5*MA-1:0]   dsp_ARID_i;
   logic [32*MA-1:0]  dsp_ARADDR_i;
   logic [2*MA-1:0]   dsp_ARBURST_i;
   logic [3*MA-1:0]   dsp_ARLEN_i;
   logic [3*MA-1:0]   dsp_ARSIZE_i;
   logic [MA-1:0]     dsp_ARVALID_i;
   logic [MA-1:0]     dsp_AR_outst_full_i;
   logic [MA-1:0]     dsp_ARREADY_o;
   logic [4:0]        s_ARID_o;
   logic [31:0]       s_ARADDR_o;
   logic [1:0]        s_ARBURST_o;
   logic [2:0]        s_ARLEN_o;
   logic [2:0]        s_ARSIZE_o;
   logic              s_ARVALID_o;
   logic              s_ARREADY_i;
   logic [4:0]        s_RID_i;
   logic [31:0]       s_RDATA_i;
   logic [1:0]        s_RRESP_i;
   logic              s_RLAST_i;
   logic              s_RVALID_i;
   logic              s_RREADY_o;
   logic [4:0]        dsp_RID_o;
   logic [31:0]       dsp_RDATA_o;
   logic [1:0]        dsp_RRESP_o;
   logic              dsp_RLAST_o;
   logic [MA-1:0]     dsp_RVALID_o;
   logic [MA-1:0]     dsp_RREADY_i;

   logic [4:0]  m_id    [MA];
   logic [31:0] m_addr  [MA];
   logic [1:0]  m_burst [MA];
   logic [2:0]  m_len   [MA];
   logic [2:0]  m_size  [MA];

   assign dsp_ARID_i    = {m_id[1], m_id[0]};
   assign dsp_ARADDR_i  = {m_addr[1], m_addr[0]};
   assign dsp_ARBURST_i = {m_burst[1], m_burst[0]};
   assign dsp_ARLEN_i   = {m_len[1], m_len[0]};
   assign dsp_ARSIZE_i  = {m_size[1], m_size[0]};

   ar_t ar_q[$];
   r_t  r_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   always #5 ACLK_i = ~ACLK_i;

   sa_read_arbiter dut (
      .ACLK_i              (ACLK_i),
      .ARESET_i            (ARESET_i),
      .dsp_ARID_i          (dsp_ARID_i),
      .dsp_ARADDR_i        (dsp_ARADDR_i),
      .dsp_ARBURST_i       (dsp_ARBURST_i),
      .dsp_ARLEN_i         (dsp_ARLEN_i),
      .dsp_ARSIZE_i        (dsp_ARSIZE_i),
      .dsp_ARVALID_i       (dsp_ARVALID_i),
      .dsp_AR_outst_full_i (dsp_AR_outst_full_i),
      .dsp_ARREADY_o       (dsp_ARREADY_o),
      .s_ARID_o            (s_ARID_o),
      .s_ARADDR_o          (s_ARADDR_o),
      .s_ARBURST_o         (s_ARBURST_o),
      .s_ARLEN_o           (s_ARLEN_o),
      .s_ARSIZE_o          (s_ARSIZE_o),
      .s_ARVALID_o         (s_ARVALID_o),
      .s_ARREADY_i         (s_ARREADY_i),
      .s_RID_i             (s_RID_i),
      .s_RDATA_i           (s_RDATA_i),
      .s_RRESP_i           (s_RRESP_i),
      .s_RLAST_i           (s_RLAST_i),
      .s_RVALID_i          (s_RVALID_i),
      .s_RREADY_o          (s_RREADY_o),
      .dsp_RID_o           (dsp_RID_o),
      .dsp_RDATA_o         (dsp_RDATA_o),
      .dsp_RRESP_o         (dsp_RRESP_o),
      .dsp_RLAST_o         (dsp_RLAST_o),
      .dsp_RVALID_o        (dsp_RVALID_o),
      .dsp_RREADY_i        (dsp_RREADY_i)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge ACLK_i);
      #1;
   endtask

   function automatic ar_t mk_ar(input int m);
      return '{id: m_id[m], addr: m_addr[m], burst: m_burst[m], len: m_len[m], size: m_size[m]};
   endfunction

   task automatic expect_grant(input string name, input logic [1:0] oh);
      @(negedge ACLK_i);
      chk(name, 64'(dsp_ARREADY_o), 64'(oh));
      cyc();
   endtask

   // Present one R beat and hold it until the slave side handshakes (bounded).
   task automatic send_beat(input logic [31:0] data, input logic last,
                            input logic [4:0] rid, input logic [1:0] oh);
      logic accepted;
      int   tries;
      accepted   = 1'b0;
      tries      = 0;
      s_RVALID_i = 1'b1;
      s_RDATA_i  = data;
      s_RLAST_i  = last;
      s_RID_i    = rid;
      s_RRESP_i  = data[1:0];
      r_q.push_back('{oh: oh, data: data, last: last, id: rid, resp: data[1:0]});
      while (!accepted && tries < 20) begin
         @(negedge ACLK_i);
         if (s_RREADY_o) accepted = 1'b1;
         cyc();
         tries++;
      end
      chk("r_beat_accepted", 64'(accepted), 64'd1);
      s_RVALID_i = 1'b0;
      s_RLAST_i  = 1'b0;
   endtask

   // AR monitor: every slave-side AR handshake must match the next expected request.
   initial begin
      ar_t e;
      forever begin
         @(negedge ACLK_i);
         if (!ARESET_i && s_ARVALID_o && s_ARREADY_i) begin
            chk("ar_expected_avail", 64'(ar_q.size() != 0), 64'd1);
            if (ar_q.size() != 0) begin
               e = ar_q.pop_front();
               chk("ar_id",    64'(s_ARID_o),    64'(e.id));
               chk("ar_addr",  64'(s_ARADDR_o),  64'(e.addr));
               chk("ar_burst", 64'(s_ARBURST_o), 64'(e.burst));
               chk("ar_len",   64'(s_ARLEN_o),   64'(e.len));
               chk("ar_size",  64'(s_ARSIZE_o),  64'(e.size));
            end
         end
      end
   end

   // R monitor: every slave-side R handshake must be steered to the expected master.
   initial begin
      r_t e;
      forever begin
         @(negedge ACLK_i);
         if (!ARESET_i && s_RVALID_i && s_RREADY_o) begin
            chk("r_expected_avail", 64'(r_q.size() != 0), 64'd1);
            if (r_q.size() != 0) begin
               e = r_q.pop_front();
               chk("r_route", 64'(dsp_RVALID_o), 64'(e.oh));
               chk("r_data",  64'(dsp_RDATA_o),  64'(e.data));
               chk("r_last",  64'(dsp_RLAST_o),  64'(e.last));
               chk("r_id",    64'(dsp_RID_o),    64'(e.id));
               chk("r_resp",  64'(dsp_RRESP_o),  64'(e.resp));
            end
         end
      end
   end

   initial begin
      ARESET_i            = 1'b1;
      dsp_ARVALID_i       = '0;
      dsp_AR_outst_full_i = '0;
      dsp_RREADY_i        = '0;
      s_ARREADY_i         = 1'b0;
      s_RVALID_i          = 1'b0;
      s_RLAST_i           = 1'b0;
      s_RDATA_i           = '0;
      s_RID_i             = '0;
      s_RRESP_i           = '0;
      m_id[0] = 5'h0A; m_addr[0] = 32'hA000_0000; m_burst[0] = 2'b01; m_len[0] = 3'd0; m_size[0] = 3'd2;
      m_id[1] = 5'h15; m_addr[1] = 32'hB000_0004; m_burst[1] = 2'b10; m_len[1] = 3'd0; m_size[1] = 3'd3;
      repeat (3) cyc();
      ARESET_i = 1'b0;

      // Reset state, then a stray slave beat with nothing outstanding.
      @(negedge ACLK_i);
      chk("rst_arvalid",  64'(s_ARVALID_o),   64'd0);
      chk("rst_arready",  64'(dsp_ARREADY_o), 64'd0);
      chk("rst_rvalid",   64'(dsp_RVALID_o),  64'd0);
      chk("rst_rready",   64'(s_RREADY_o),    64'd0);
      chk("rst_arid",     64'(s_ARID_o),      64'd0);
      chk("rst_araddr",   64'(s_ARADDR_o),    64'd0);
      cyc();
      dsp_RREADY_i = 2'b11;
      s_RVALID_i   = 1'b1;
      s_RLAST_i    = 1'b1;
      s_RDATA_i    = 32'h5555_0000;
      repeat (2) begin
         @(negedge ACLK_i);
         chk("stray_rready", 64'(s_RREADY_o),   64'd0);
         chk("stray_rvalid", 64'(dsp_RVALID_o), 64'd0);
         cyc();
      end
      s_RVALID_i = 1'b0;
      s_RLAST_i  = 1'b0;

      // Master 0 holds the pointer but is outstanding-full: no grant until released.
      s_ARREADY_i         = 1'b1;
      dsp_ARVALID_i       = 2'b01;
      dsp_AR_outst_full_i = 2'b01;
      repeat (2) begin
         @(negedge ACLK_i);
         chk("masked_no_grant", 64'(dsp_ARREADY_o), 64'd0);
         chk("masked_no_arvalid", 64'(s_ARVALID_o), 64'd0);
         cyc();
      end
      dsp_AR_outst_full_i = 2'b00;
      ar_q.push_back(mk_ar(0));
      expect_grant("unmask_grant0", 2'b01);
      dsp_ARVALID_i = 2'b00;
      cyc();
      send_beat(32'hC000_0001, 1'b1, m_id[0], 2'b01);
      ARESET_i = 1'b1;
      cyc();
      ARESET_i = 1'b0;

      // Alternating grants from pointer 0 until the ordering FIFO holds 8.
      dsp_ARVALID_i = 2'b11;
      for (int k = 0; k < 8; k++) begin
         ar_q.push_back(mk_ar(k % 2));
         expect_grant($sformatf("alt_grant_%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      repeat (2) begin
         @(negedge ACLK_i);
         chk("fifo_full_hold", 64'(dsp_ARREADY_o), 64'd0);
         cyc();
      end
      s_RVALID_i = 1'b1;
      s_RLAST_i  = 1'b1;
      s_RDATA_i  = 32'hC100_0000;
      s_RID_i    = m_id[0];
      s_RRESP_i  = 2'b00;
      r_q.push_back('{oh: 2'b01, data: 32'hC100_0000, last: 1'b1, id: m_id[0], resp: 2'b00});
      @(negedge ACLK_i);
      chk("pop_cycle_no_grant", 64'(dsp_ARREADY_o), 64'd0);
      chk("pop_cycle_rready",   64'(s_RREADY_o),    64'd1);
      cyc();
      s_RVALID_i = 1'b0;
      s_RLAST_i  = 1'b0;
      ar_q.push_back(mk_ar(0));
      expect_grant("grant_after_pop", 2'b01);
      dsp_ARVALID_i = 2'b00;
      repeat (2) cyc();
      for (int k = 0; k < 8; k++) begin
         send_beat(32'hC200_0000 + 32'(k), 1'b1, m_id[(k + 1) % 2],
                   (k % 2 == 0) ? 2'b10 : 2'b01);
      end

      // Grants to 1 then 0 with multi-beat bursts returned in order.
      m_len[1] = 3'd3;
      m_len[0] = 3'd1;
      dsp_ARVALID_i = 2'b11;
      ar_q.push_back(mk_ar(1));
      expect_grant("burst_grant1", 2'b10);
      ar_q.push_back(mk_ar(0));
      expect_grant("burst_grant0", 2'b01);
      dsp_ARVALID_i = 2'b00;
      cyc();
      send_beat(32'hD100_0000, 1'b0, m_id[1], 2'b10);
      dsp_RREADY_i = 2'b01;
      s_RVALID_i   = 1'b1;
      s_RDATA_i    = 32'hD100_0001;
      s_RLAST_i    = 1'b0;
      repeat (2) begin
         @(negedge ACLK_i);
         chk("stall_rready", 64'(s_RREADY_o),   64'd0);
         chk("stall_rvalid", 64'(dsp_RVALID_o), 64'h2);
         cyc();
      end
      dsp_RREADY_i = 2'b11;
      send_beat(32'hD100_0001, 1'b0, m_id[1], 2'b10);
      send_beat(32'hD100_0002, 1'b0, m_id[1], 2'b10);
      send_beat(32'hD100_0003, 1'b1, m_id[1], 2'b10);
      send_beat(32'hD200_0000, 1'b0, m_id[0], 2'b01);
      send_beat(32'hD200_0001, 1'b1, m_id[0], 2'b01);

      // Slave back-pressure on AR: payload must hold and no new grant issued.
      m_len[1]      = 3'd0;
      m_len[0]      = 3'd0;
      m_addr[1]     = 32'hB000_0100;
      s_ARREADY_i   = 1'b0;
      dsp_ARVALID_i = 2'b10;
      ar_q.push_back(mk_ar(1));
      expect_grant("bp_grant1", 2'b10);
      m_addr[1]     = 32'hB000_0200;
      dsp_ARVALID_i = 2'b11;
      repeat (3) begin
         @(negedge ACLK_i);
         chk("bp_no_grant",   64'(dsp_ARREADY_o), 64'd0);
         chk("bp_addr_hold",  64'(s_ARADDR_o),    64'hB000_0100);
         chk("bp_id_hold",    64'(s_ARID_o),      64'h15);
         chk("bp_valid_hold", 64'(s_ARVALID_o),   64'd1);
         cyc();
      end
      s_ARREADY_i = 1'b1;
      ar_q.push_back(mk_ar(0));
      expect_grant("bp_release_grant0", 2'b01);
      dsp_ARVALID_i = 2'b00;
      repeat (2) cyc();

      // Reset in the middle of a burst wipes ownership; the pending beat is not taken.
      send_beat(32'hE000_0000, 1'b0, m_id[1], 2'b10);
      s_RVALID_i = 1'b1;
      s_RDATA_i  = 32'hE000_0001;
      ARESET_i   = 1'b1;
      cyc();
      ARESET_i = 1'b0;
      @(negedge ACLK_i);
      chk("midrst_rvalid",  64'(dsp_RVALID_o),  64'd0);
      chk("midrst_rready",  64'(s_RREADY_o),    64'd0);
      chk("midrst_arvalid", 64'(s_ARVALID_o),   64'd0);
      chk("midrst_arready", 64'(dsp_ARREADY_o), 64'd0);
      cyc();
      s_RVALID_i = 1'b0;
      repeat (2) cyc();

      chk("ar_queue_drained", 64'(ar_q.size()), 64'd0);
      chk("r_queue_drained",  64'(r_q.size()),  64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sa_read_arbiter.md
Name: sa_read_arbiter

Overview:
- Slave-side read arbiter of the AXI4 interconnect; one instance per slave port.
- Shares one slave's AR channel between the MST_AMT per-master read dispatchers using round-robin arbitration.
- Records the grant order in an ordering FIFO.
- Steers the slave's R beats back to the owning dispatcher until RLAST.
- The slave returns read bursts in AR acceptance order; this block relies on that.

Parameters:
- MST_AMT, 2, number of requesting master dispatchers
- OUTSTANDING_AMT, 8, max accepted-but-uncompleted bursts (ordering FIFO depth)
- DATA_WIDTH, 32, RDATA width
- ADDR_WIDTH, 32, ARADDR width
- TRANS_MST_ID_W, 5, ARID/RID width
- TRANS_BURST_W, 2, ARBURST width
- TRANS_DATA_LEN_W, 3, ARLEN width
- TRANS_DATA_SIZE_W, 3, ARSIZE width
- TRANS_WR_RESP_W, 2, RRESP width
- MST_ID_W, $clog2(MST_AMT) (min 1), master index width

Ports:
- ACLK_i  in  1  clock; one clock domain
- ARESET_i  in  1  reset; synchronous, active-high
- dsp_ARID_i  in  TRANS_MST_ID_W*MST_AMT  per-master ARID, master m at slice m
- dsp_ARADDR_i  in  ADDR_WIDTH*MST_AMT  per-master ARADDR
- dsp_ARBURST_i  in  TRANS_BURST_W*MST_AMT  per-master ARBURST
- dsp_ARLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master ARLEN
- dsp_ARSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master ARSIZE
- dsp_ARVALID_i  in  MST_AMT  per-master AR valid
- dsp_AR_outst_full_i  in  MST_AMT  dispatcher outstanding-full; masks that master from arbitration
- dsp_ARREADY_o  out  MST_AMT  one-hot grant/accept
- s_ARID_o, s_ARADDR_o, s_ARBURST_o, s_ARLEN_o, s_ARSIZE_o  out  single-width each  registered AR payload to slave
- s_ARVALID_o  out  1  AR valid to slave
- s_ARREADY_i  in  1  slave AR ready
- s_RID_i  in  TRANS_MST_ID_W  slave RID
- s_RDATA_i  in  DATA_WIDTH  slave RDATA
- s_RRESP_i  in  TRANS_WR_RESP_W  slave RRESP
- s_RLAST_i  in  1  slave RLAST
- s_RVALID_i  in  1  slave RVALID
- s_RREADY_o  out  1  RREADY to slave
- dsp_RID_o, dsp_RDATA_o, dsp_RRESP_o, dsp_RLAST_o  out  single-width each  R payload broadcast to all dispatchers
- dsp_RVALID_o  out  MST_AMT  one-hot R valid
- dsp_RREADY_i  in  MST_AMT  per-master R ready

Behaviour:
- Reset (ARESET_i high at a clock edge):
  - s_ARVALID_o=0, AR payload regs=0, dsp_ARREADY_o=0.
  - RR pointer=0; ordering FIFO empty (count=0), so dsp_RVALID_o=0 and s_RREADY_o=0.
  - Reset mid-burst discards all state; no pending beat is completed.
- Eligible request: req[m] = dsp_ARVALID_i[m] & ~dsp_AR_outst_full_i[m].
- Grant enable: gnt_en = (~s_ARVALID_o | s_ARREADY_i) & (fifo_count < OUTSTANDING_AMT). A pop in the same cycle does not free a slot for this cycle's grant.
- Arbitration (combinational, same cycle):
  - With gnt_en and any req, grant the first requester at or after the RR pointer, wrapping modulo MST_AMT.
  - dsp_ARREADY_o[g]=1 for exactly that cycle.
- On the grant edge:
  - Load the AR payload regs from slice g; set s_ARVALID_o=1.
  - Push g into the ordering FIFO.
  - Set pointer = (g+1) mod MST_AMT.
- Without a new grant: s_ARVALID_o clears after s_ARREADY_i. Payload stays stable while s_ARVALID_o=1 and s_ARREADY_i=0.
- AR latency and throughput:
  - Dispatcher handshake to s_ARVALID_o is 1 cycle.
  - Back-to-back grants are allowed when the slave accepts every cycle (1 AR/cycle).
- AR state: IDLE (s_ARVALID_o=0) and PEND (s_ARVALID_o=1).
  - IDLE -> PEND on grant.
  - PEND -> IDLE on s_ARREADY_i without a new grant.
  - PEND -> PEND on s_ARREADY_i with a new grant.
- R routing (combinational, 0 latency), with head = FIFO head, valid when count>0:
  - dsp_RVALID_o[head] = s_RVALID_i; all other dsp_RVALID_o bits 0.
  - s_RREADY_o = dsp_RREADY_i[head].
  - R payload is passed through unchanged.
- R with FIFO empty: s_RREADY_o=0 and all dsp_RVALID_o=0. Stray slave beats stall and are never dropped.
- FIFO pop: on s_RVALID_i & s_RREADY_o & s_RLAST_i.
- FIFO count: push and pop in the same cycle leave count unchanged. Count width is $clog2(OUTSTANDING_AMT)+1. Pointers wrap modulo OUTSTANDING_AMT.
- Masked requester: a master with outst_full=1 is skipped even if it holds the RR pointer. The pointer does not move when there is no grant.

Decomposition:
- Shared package (axi_icn_pkg):
  - width constants: TRANS_MST_ID_W, TRANS_BURST_W, TRANS_DATA_LEN_W, TRANS_DATA_SIZE_W, TRANS_WR_RESP_W;
  - MST_ID_W function;
  - AR state encoding localparams (ST_IDLE, ST_PEND).
- One sub-module: sa_order_fifo, a sync FIFO (width MST_ID_W, depth OUTSTANDING_AMT) with push/pop/full/empty/count. The RR arbiter stays inline.

Test Plan:
- Reset, then idle: all valids and readys 0, count 0. An s_RVALID_i=1 beat with FIFO empty -> s_RREADY_o stays 0.
- MST_AMT=2, both request continuously, s_ARREADY_i=1 -> grants alternate 0,1,0,1; s_ARID_o follows each master's ID one cycle after its grant.
- Master 0 requests with dsp_AR_outst_full_i[0]=1, master 1 idle -> no grant. Release full -> grant to 0 next cycle.
- Push 8 grants with no R traffic -> the 9th request is held (dsp_ARREADY_o=0). One RLAST beat -> the grant proceeds the following cycle.
- Grants to 1 then 0, slave returns ARLEN=3 then ARLEN=1 bursts in order -> 4 beats steered to master 1, then 2 beats to master 0. dsp_RREADY_i[1]=0 for 2 cycles stalls s_RREADY_o.
- Slave holds s_ARREADY_i=0 for 3 cycles -> s_AR payload stable, no new grants. ARESET_i mid-burst -> FIFO empty, all valids 0.
